mult_lut_seq_ctrl: RTL and testbench
====================================

# mult_lut_seq_ctrl

Sequential controller that computes a 16x16 unsigned product by time-multiplexing one shared `MULT_LUT_2_BITS` stage over eight cycles, instead of the fully parallel `MULT_LUT_16_BITS` tree. It sits between a requesting FSM (start/done handshake) and the multiplier datapath. It owns operand latching, radix-4 digit sequencing, shift-accumulate and result hold, trading latency for area.

## Interface
- No parameters; widths are fixed: 16-bit operands, 32-bit result.
- `Clock` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-low; clears all state immediately.
- `iStart` input 1: request pulse or level; sampled only in IDLE or DONE.
- `iDato_A` input 16: multiplicand; latched on accepted start.
- `iDato_B` input 16: multiplier; latched on accepted start.
- `oBusy` output 1: high while in RUN.
- `oDone` output 1: one-cycle pulse, high while in DONE.
- `oResult` output 32: product; valid from DONE onward, held until the next accepted start.

## Operation
- Registers:
  - `rA[15:0]`, `rB[15:0]` (shifted right by 2 per step)
  - `rAcc[31:0]`
  - `rCnt[2:0]` (digit index 0..7)
  - `rState` (IDLE, RUN, DONE)
- Datapath: one `MULT_LUT_2_BITS` instance, fed `rA` and `rB[1:0]`. Partial product is at most 0x2FFFD (18 bits), zero-extended to 32 bits.
- Accumulate: each RUN cycle does `rAcc <= rAcc + (pp << (2*rCnt))`; shift ≤ 14. The sum never exceeds 0xFFFE0001, so there is no overflow and no truncation.
- IDLE:
  - `iStart=1` → RUN. Latch `rA=iDato_A`, `rB=iDato_B`, clear `rAcc`, set `rCnt=0`.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle: accumulate, shift `rB` right by 2, increment `rCnt`.
  - When `rCnt==7` (or the early-exit condition holds, see Configuration) → DONE.
  - `iStart` is ignored. Operand inputs are ignored in all states except on an accepted start.
- DONE:
  - `oResult <= rAcc` is loaded on entry.
  - `iStart=1` → RUN with a fresh latch, identical to IDLE acceptance (back-to-back operation).
  - Otherwise → IDLE.
- `oResult` is a separate register, so it is stable through IDLE and the whole of the next RUN until the next DONE.
- Reset (asynchronous, any state, including mid-RUN): state=IDLE; `rA`, `rB`, `rAcc`, `rCnt`, `oResult` all 0; `oBusy=0`, `oDone=0`. A partial product in flight is discarded; there is no resume.

## Timing
- Edge E0 samples `iStart`; edges E1..E8 perform the 8 accumulate steps.
- State is DONE after E8; `oDone=1` and `oResult` are valid in the cycle between E8 and E9.
- `oBusy` is high in cycles E0→E8 (8 cycles).
- Throughput: one product per 9 cycles when `iStart` is held high continuously (DONE→RUN directly).
- Outputs are registered or decoded from `rState` only; there are no combinational paths from inputs to outputs.

## Configuration
- `MULT_SEQ_EARLY_EXIT_EN` defined:
  - In RUN, transition to DONE on the edge where the post-shift `rB` is zero, even if `rCnt<7`.
  - Latency becomes ceil((index of highest set bit of B + 1)/2) steps, with a minimum of 1.
  - B=0 takes 1 step, giving result 0.
- Undefined: always exactly 8 RUN steps, giving fixed latency regardless of B.
- The result value is identical in both builds.

## Test plan
- A=0x1234, B=0x5678, single start pulse: `oDone` pulses for 1 cycle after E8; `oResult=0x06260060`; `oBusy` high for 8 cycles.
- A=0xFFFF, B=0xFFFF: `oResult=0xFFFE0001`. A=0x0000, B=0xABCD: `oResult=0` (latency unchanged without the macro).
- `iStart` held high, operands A=3/B=5, then A=7/B=9 changed after the first accept: consecutive `oDone` pulses exactly 9 cycles apart, `oResult` 0x0000000F then 0x0000003F. `iStart` pulses during RUN are ignored, and operand changes during RUN do not affect the result.
- Start A=0x1234, B=0x5678, assert `Reset` low asynchronously mid-RUN (after E4, between edges): all outputs 0 immediately. After release, a new start with A=2, B=3 gives `oResult=6`.
- With `MULT_SEQ_EARLY_EXIT_EN`: A=0x00FF, B=0x0003 gives `oDone` after E1 with `oResult=0x000002FD`. B=0x8000, A=1 gives `oDone` after E8 with `oResult=0x00008000`.

Source files
------------

// File: rtl/mult_lut_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier: one shared radix-4 LUT stage, eight shift-accumulate steps.
// Optional build macro MULT_SEQ_EARLY_EXIT_EN finishes as soon as the remaining multiplier digits are zero.

module MULT_LUT_2_BITS (
  input  logic [15:0] a,
  input  logic [1:0]  digit,
  output logic [17:0] pp
);
  always_comb begin
    case (digit)
      2'd0:    pp = 18'd0;
      2'd1:    pp = {2'b00, a};
      2'd2:    pp = {1'b0, a, 1'b0};
      default: pp = {2'b00, a} + {1'b0, a, 1'b0};
    endcase
  end
endmodule

module mult_lut_seq_ctrl (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iStart,
  input  logic [15:0] iDato_A,
  input  logic [15:0] iDato_B,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oResult
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] b_reg, b_next;
  logic [31:0] acc_reg, acc_next;
  logic [31:0] result_reg, result_next;
  logic [2:0]  cnt_reg, cnt_next;

  logic [17:0] pp;
  logic [15:0] b_shift;
  logic [31:0] acc_sum;
  logic        last_step;

  MULT_LUT_2_BITS u_lut (
    .a     (a_reg),
    .digit (b_reg[1:0]),
    .pp    (pp)
  );

  assign b_shift = {2'b00, b_reg[15:2]};
  // Digit weight is 4^cnt, so the partial product moves left by 2*cnt.
  assign acc_sum = acc_reg + ({14'd0, pp} << {cnt_reg, 1'b0});

`ifdef MULT_SEQ_EARLY_EXIT_EN
  assign last_step = (cnt_reg == 3'd7) || (b_shift == 16'd0);
`else
  assign last_step = (cnt_reg == 3'd7);
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= IDLE;
      a_reg      <= 16'd0;
      b_reg      <= 16'd0;
      acc_reg    <= 32'd0;
      result_reg <= 32'd0;
      cnt_reg    <= 3'd0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    cnt_next    = cnt_reg;
    oBusy       = 1'b0;
    oDone       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (iStart) begin
          state_next = RUN;
          a_next     = iDato_A;
          b_next     = iDato_B;
          acc_next   = 32'd0;
          cnt_next   = 3'd0;
        end
      end
      RUN: begin
        oBusy    = 1'b1;
        acc_next = acc_sum;
        b_next   = b_shift;
        cnt_next = cnt_reg + 3'd1;
        if (last_step) begin
          state_next  = DONE;
          // Capture the final sum directly so the result is valid in the DONE cycle.
          result_next = acc_sum;
        end
      end
      DONE: begin
        oDone = 1'b1;
        if (iStart) begin
          state_next = RUN;
          a_next     = iDato_A;
          b_next     = iDato_B;
          acc_next   = 32'd0;
          cnt_next   = 3'd0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign oResult = result_reg;

endmodule

// File: tb/tb_mult_lut_seq_ctrl.sv
// Self-checking bench for mult_lut_seq_ctrl: directed, randomized, back-to-back and async-reset scenarios.
// Expected products and latencies come from plain arithmetic on the operands.

module tb_mult_lut_seq_ctrl;
  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic [15:0] iDato_A;
  logic [15:0] iDato_B;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;

  int n_tests = 0;
  int n_fail  = 0;

  mult_lut_seq_ctrl dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iDato_A (iDato_A),
    .iDato_B (iDato_B),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oResult (oResult)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Number of RUN steps expected for a given multiplier.
  function automatic int ref_latency(input logic [15:0] b);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < 16; i++) if (b[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + 2) / 2;
`else
    return 8;
`endif
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string name);
    int cycles;
    int busy;
    @(negedge Clock);
    iStart = 1'b1; iDato_A = a; iDato_B = b;
    @(posedge Clock); #1;
    iStart = 1'b0;
    cycles = 0; busy = 0;
    while (oDone !== 1'b1 && cycles < 30) begin
      if (oBusy === 1'b1) busy++;
      // Start pulses and operand changes during RUN must have no effect.
      iStart  = 1'($urandom_range(0, 1));
      iDato_A = 16'($urandom);
      iDato_B = 16'($urandom);
      @(posedge Clock); #1;
      cycles++;
    end
    iStart = 1'b0;
    $display("[TB] %s A=%h B=%h result=%h cycles=%0d busy=%0d", name, a, b, oResult, cycles, busy);
    n_tests++;
    if (oDone !== 1'b1) begin
      n_fail++; $display("FAIL %s done_timeout: got oDone=%b want 1", name, oDone);
    end
    n_tests++;
    if (cycles !== exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", name, cycles, exp_lat);
    end
    n_tests++;
    if (busy !== exp_lat) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy, exp_lat);
    end
    n_tests++;
    if (oResult !== exp_res) begin
      n_fail++; $display("FAIL %s result: got %h want %h", name, oResult, exp_res);
    end
    @(posedge Clock); #1;
    n_tests++;
    if (oDone !== 1'b0 || oBusy !== 1'b0 || oResult !== exp_res) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b res=%h want done=0 busy=0 res=%h",
               name, oDone, oBusy, oResult, exp_res);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; iStart = 1'b1; iDato_A = 16'h1234; iDato_B = 16'h5678;
    repeat (3) @(posedge Clock);
    #1;
    $display("[TB] reset state busy=%b done=%b result=%h", oBusy, oDone, oResult);
    n_tests++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h want 0 0 0", oBusy, oDone, oResult);
    end
    iStart = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    n_tests++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", oBusy, oDone);
    end
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h5678, 32'h06260060, ref_latency(16'h5678), "dir_1234x5678");
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, ref_latency(16'hFFFF), "dir_max");
    run_op(16'h0000, 16'hABCD, 32'h00000000, ref_latency(16'hABCD), "dir_zeroA");
    run_op(16'hBEEF, 16'h0000, 32'h00000000, ref_latency(16'h0000), "dir_zeroB");
`ifdef MULT_SEQ_EARLY_EXIT_EN
    run_op(16'h00FF, 16'h0003, 32'h000002FD, 1, "early_b3");
    run_op(16'h0001, 16'h8000, 32'h00008000, 8, "early_b8000");
`endif
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom);
      b = 16'($urandom) >> $urandom_range(0, 16);
      run_op(a, b, 32'(a) * 32'(b), ref_latency(b), "random");
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    int gap;
    @(negedge Clock);
    iStart = 1'b1; iDato_A = 16'd3; iDato_B = 16'd5;
    @(posedge Clock); #1;
    iDato_A = 16'd7; iDato_B = 16'd9;
    cycles = 0;
    while (oDone !== 1'b1 && cycles < 30) begin
      @(posedge Clock); #1;
      cycles++;
    end
    $display("[TB] b2b first result=%h cycles=%0d", oResult, cycles);
    n_tests++;
    if (oDone !== 1'b1 || cycles !== ref_latency(16'd5) || oResult !== 32'h0000000F) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b cycles=%0d res=%h want 1 %0d 0000000f",
               oDone, cycles, oResult, ref_latency(16'd5));
    end
    gap = 0;
    do begin
      @(posedge Clock); #1;
      gap++;
      if (gap == 1) begin
        n_tests++;
        if (oBusy !== 1'b1 || oDone !== 1'b0 || oResult !== 32'h0000000F) begin
          n_fail++;
          $display("FAIL b2b_hold: got busy=%b done=%b res=%h want 1 0 0000000f", oBusy, oDone, oResult);
        end
      end
    end while (oDone !== 1'b1 && gap < 40);
    iStart = 1'b0;
    $display("[TB] b2b second result=%h gap=%0d", oResult, gap);
    n_tests++;
    if (gap !== ref_latency(16'd9) + 1) begin
      n_fail++; $display("FAIL b2b_gap: got %0d want %0d", gap, ref_latency(16'd9) + 1);
    end
    n_tests++;
    if (oResult !== 32'h0000003F) begin
      n_fail++; $display("FAIL b2b_second: got %h want 0000003f", oResult);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_async_reset();
    @(negedge Clock);
    iStart = 1'b1; iDato_A = 16'h1234; iDato_B = 16'h5678;
    @(posedge Clock); #1;
    iStart = 1'b0;
    repeat (4) @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    $display("[TB] async reset busy=%b done=%b result=%h", oBusy, oDone, oResult);
    n_tests++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b res=%h want 0 0 0", oBusy, oDone, oResult);
    end
    @(negedge Clock);
    Reset = 1'b1;
    run_op(16'd2, 16'd3, 32'd6, ref_latency(16'd3), "post_reset");
  endtask

  initial begin
    iStart = 1'b0; iDato_A = 16'd0; iDato_B = 16'd0; Reset = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
